// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO, any depth >= 2, with count, almost flags, sticky errors; FWFT or 1-cycle registered read.
// Backpressure: writes dropped while wr_full, reads dropped while rd_empty; all flags registered.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_TH      = 14,
  parameter int AE_TH      = 2,
  parameter int REG_OUT    = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           write,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_full,
  output logic                           almost_full,
  input  logic                           read,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic                           rd_empty,
  output logic                           almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_lap_q, wr_lap_d;
  logic          rd_lap_q, rd_lap_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_full_q, wr_full_d;
  logic          rd_empty_q, rd_empty_d;
  logic          almost_full_q, almost_full_d;
  logic          almost_empty_q, almost_empty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_accept;
  logic          rd_accept;

  always_comb begin
    wr_accept = write & ~wr_full_q;
    rd_accept = read & ~rd_empty_q;

    // Non-power-of-2 depth: the address wraps explicitly and the lap bit tells full from empty.
    wr_addr_d = wr_addr_q;
    wr_lap_d  = wr_lap_q;
    if (wr_accept) begin
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_d = '0;
        wr_lap_d  = ~wr_lap_q;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end

    rd_addr_d = rd_addr_q;
    rd_lap_d  = rd_lap_q;
    if (rd_accept) begin
      if (rd_addr_q == LAST_ADDR) begin
        rd_addr_d = '0;
        rd_lap_d  = ~rd_lap_q;
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end

    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    wr_full_d      = (wr_addr_d == rd_addr_d) && (wr_lap_d != rd_lap_d);
    rd_empty_d     = (wr_addr_d == rd_addr_d) && (wr_lap_d == rd_lap_d);
    almost_full_d  = (count_d >= CW'(AF_TH));
    almost_empty_d = (count_d <= CW'(AE_TH));
    overflow_d     = overflow_q  | (write & wr_full_q);
    underflow_d    = underflow_q | (read & rd_empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      wr_lap_q       <= 1'b0;
      rd_lap_q       <= 1'b0;
      count_q        <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      wr_lap_q       <= wr_lap_d;
      rd_lap_q       <= rd_lap_d;
      count_q        <= count_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_addr_q] <= wr_data;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_accept;
        if (rd_accept) begin
          rd_data_d = mem[rd_addr_q];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft
      assign rd_data  = mem[rd_addr_q];
      assign rd_valid = ~rd_empty_q;
    end
  endgenerate

  assign wr_full      = wr_full_q;
  assign rd_empty     = rd_empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  a_not_full_and_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_full_q && rd_empty_q));
  a_count_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CW'(DEPTH));

endmodule
